dtcm_ctrl: RTL and testbench
============================

# dtcm_ctrl

Data tightly-coupled memory controller sitting directly downstream of the LSU. It accepts the LSU's DTCM command stream (valid/ready), drives a single-port synchronous SRAM macro with one-cycle read latency, and returns exactly one in-order response per command. A small response buffer absorbs LSU back-pressure, so the SRAM never needs to stall mid-access.

## Interface
Parameters:
- AW, default 16: byte-address width of dtcm_cmd_addr; SRAM depth is 2^(AW-2) words.
- DW, default 32: data width (XLEN).
- RSP_DEPTH, default 2: response buffer entries, minimum 2.

Ports:
- Clock and reset: one clock; reset is asynchronous and active-low.
  - clk  in  1  clock.
  - rst_n  in  1  asynchronous active-low reset.
- Command channel from the LSU:
  - dtcm_cmd_valid  in  1  command valid.
  - dtcm_cmd_ready  out  1  command accepted when valid and ready are both high.
  - dtcm_cmd_read  in  1  1 = read, 0 = write.
  - dtcm_cmd_addr  in  AW  byte address; bits [1:0] are ignored (alignment is checked upstream).
  - dtcm_cmd_wdata  in  DW  write data.
  - dtcm_cmd_wmask  in  DW/8  byte write enables.
- Response channel to the LSU:
  - dtcm_rsp_valid  out  1  response valid.
  - dtcm_rsp_ready  in  1  response consumed when valid and ready are both high.
  - dtcm_rsp_rdata  out  DW  read data; 0 for write responses.
- SRAM macro:
  - ram_cs  out  1  chip select.
  - ram_we  out  1  write enable.
  - ram_addr  out  AW-2  word address.
  - ram_wem  out  DW/8  byte write mask.
  - ram_din  out  DW  write data.
  - ram_dout  in  DW  read data, valid in the cycle after a read with cs=1 and we=0; undefined otherwise.

## Operation
- State:
  - pending (1b): an access was issued last cycle.
  - pend_rd (1b): that access was a read.
  - count (0..RSP_DEPTH): buffer occupancy.
  - head and tail pointers, wrapping modulo RSP_DEPTH.
- Credit: dtcm_cmd_ready = rst_n & ((count + pending) < RSP_DEPTH). It is computed from registered state only; there is no combinational path from dtcm_rsp_ready.
- Accept (fire = dtcm_cmd_valid & dtcm_cmd_ready):
  - ram_cs = fire.
  - ram_we = fire & ~dtcm_cmd_read.
  - ram_addr = dtcm_cmd_addr[AW-1:2].
  - ram_wem = dtcm_cmd_wmask.
  - ram_din = dtcm_cmd_wdata.
  - On the next edge: pending <= fire; pend_rd <= fire & dtcm_cmd_read.
- Response data:
  - rsp_cur = pend_rd ? ram_dout : 0.
  - dtcm_rsp_valid = (count != 0) | pending.
  - dtcm_rsp_rdata = (count != 0) ? buf[head] : rsp_cur.
  - When count = 0, the response falls through directly from SRAM.
- Pop: when count != 0 and dtcm_rsp_ready, head advances and count decrements.
- Push: when pending and not (count == 0 and dtcm_rsp_ready), rsp_cur is written to buf[tail], tail advances and count increments.
- Push and pop in the same cycle leave count unchanged. Push never happens when full; the credit rule guarantees this.
- Ordering is strict FIFO: the buffered head always precedes the in-flight SRAM result.
- A write accepted with wmask = 0 still produces a response but modifies no memory.

## Timing
- Reset values: pending = 0, pend_rd = 0, count = 0, head = tail = 0.
- Outputs under reset:
  - dtcm_rsp_valid = 0.
  - dtcm_cmd_ready = 0 while rst_n is low, and 1 in the first cycle after release.
  - ram_cs = 0, ram_we = 0.
- Latency: a command accepted in cycle n gives dtcm_rsp_valid in cycle n+1 if the buffer is empty. Otherwise the response follows the queued ones.
- Throughput: one command per cycle while dtcm_rsp_ready stays high (steady state pending = 1, count = 0).
- Back-pressure: with dtcm_rsp_ready low, at most RSP_DEPTH commands are outstanding, after which dtcm_cmd_ready drops.
  - Once ready returns, one pop frees one credit on the next cycle.
- dtcm_rsp_valid and dtcm_rsp_rdata are held stable while valid is high and ready is low. rsp_cur is captured into the buffer in the same cycle, so SRAM dout changes cannot corrupt it.
- Reset mid-operation: in-flight and buffered responses are discarded. An SRAM write already strobed is allowed to complete.

## Test plan
- Write then read: write 0xDEADBEEF to addr 0x0010 with mask 0xF, then read 0x0010 with rsp_ready = 1.
  - Write response rdata = 0 in cycle n+1; read rdata = 0xDEADBEEF in cycle n+3.
- Byte mask: write 0x11223344 with mask 0x5 over 0xFFFFFFFF, then read.
  - Read rdata = 0xFF22FF44.
- Back-to-back: 8 consecutive reads of preloaded words with rsp_ready always 1.
  - dtcm_cmd_ready stays 1 throughout; 8 responses in consecutive cycles, in order.
- Back-pressure: issue 4 reads while rsp_ready = 0.
  - Only 2 are accepted, then cmd_ready = 0; rsp_valid stays high with the first data held stable.
  - Raising ready drains both responses in order, and cmd_ready returns the cycle after the first pop.
- Mixed pop and push: alternate rsp_ready 1/0 under continuous reads.
  - count never exceeds 2; a scoreboard sees no loss or reordering.
- Reset mid-operation: assert rst_n low with 2 responses buffered.
  - rsp_valid = 0 immediately; after release, cmd_ready = 1 and no stale response appears.

Source files
------------

// File: rtl/dtcm_ctrl_if.sv
// LSU <-> DTCM command/response channel.
// The master is the LSU side, the slave is the controller.
interface dtcm_if #(
    parameter int AW = 16,
    parameter int DW = 32
);
    logic          dtcm_cmd_valid;
    logic          dtcm_cmd_ready;
    logic          dtcm_cmd_read;
    logic [AW-1:0] dtcm_cmd_addr;
    logic [DW-1:0] dtcm_cmd_wdata;
    logic [DW/8-1:0] dtcm_cmd_wmask;
    logic          dtcm_rsp_valid;
    logic          dtcm_rsp_ready;
    logic [DW-1:0] dtcm_rsp_rdata;

    modport master (
        output dtcm_cmd_valid,
        output dtcm_cmd_read,
        output dtcm_cmd_addr,
        output dtcm_cmd_wdata,
        output dtcm_cmd_wmask,
        input  dtcm_cmd_ready,
        input  dtcm_rsp_valid,
        input  dtcm_rsp_rdata,
        output dtcm_rsp_ready
    );

    modport slave (
        input  dtcm_cmd_valid,
        input  dtcm_cmd_read,
        input  dtcm_cmd_addr,
        input  dtcm_cmd_wdata,
        input  dtcm_cmd_wmask,
        output dtcm_cmd_ready,
        output dtcm_rsp_valid,
        output dtcm_rsp_rdata,
        input  dtcm_rsp_ready
    );
endinterface

// File: rtl/dtcm_ctrl.sv
// Data TCM controller: LSU command/response bridge onto a 1-cycle SRAM.
// Responses fall through when idle, otherwise queue in a small FIFO.
module dtcm_ctrl #(
    parameter int AW        = 16,
    parameter int DW        = 32,
    parameter int RSP_DEPTH = 2
) (
    input  logic            clk,
    input  logic            rst_n,
    dtcm_if.slave           lsu,
    output logic            ram_cs,
    output logic            ram_we,
    output logic [AW-3:0]   ram_addr,
    output logic [DW/8-1:0] ram_wem,
    output logic [DW-1:0]   ram_din,
    input  logic [DW-1:0]   ram_dout
);
    localparam int PW = (RSP_DEPTH > 1) ? $clog2(RSP_DEPTH) : 1;
    localparam int CW = $clog2(RSP_DEPTH + 1);
    localparam logic [PW-1:0] LAST    = PW'(RSP_DEPTH - 1);
    localparam logic [CW:0]   CREDITS = (CW + 1)'(RSP_DEPTH);

    logic          pending;
    logic          pend_rd;
    logic [CW-1:0] count;
    logic [PW-1:0] head;
    logic [PW-1:0] tail;
    logic [DW-1:0] rsp_buf [RSP_DEPTH];

    logic          fire;
    logic          pop;
    logic          push;
    logic          buf_empty;
    logic [CW:0]   in_use;
    logic [DW-1:0] rsp_cur;
    logic          unused_addr;

    function automatic logic [PW-1:0] wrap_inc(input logic [PW-1:0] p);
        return (p == LAST) ? '0 : p + 1'b1;
    endfunction

    // Credit counts both buffered and in-flight responses, so an
    // accepted command always has a slot waiting for its SRAM result.
    assign buf_empty = (count == '0);
    assign in_use    = {1'b0, count} + (CW + 1)'(pending);

    assign lsu.dtcm_cmd_ready = rst_n & (in_use < CREDITS);
    assign fire = lsu.dtcm_cmd_valid & lsu.dtcm_cmd_ready;

    assign ram_cs   = fire;
    assign ram_we   = fire & ~lsu.dtcm_cmd_read;
    assign ram_addr = lsu.dtcm_cmd_addr[AW-1:2];
    assign ram_wem  = lsu.dtcm_cmd_wmask;
    assign ram_din  = lsu.dtcm_cmd_wdata;

    assign unused_addr = ^lsu.dtcm_cmd_addr[1:0];

    assign rsp_cur = pend_rd ? ram_dout : '0;

    assign lsu.dtcm_rsp_valid = ~buf_empty | pending;
    assign lsu.dtcm_rsp_rdata = buf_empty ? rsp_cur : rsp_buf[head];

    assign pop  = ~buf_empty & lsu.dtcm_rsp_ready;
    assign push = pending & ~(buf_empty & lsu.dtcm_rsp_ready);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pending <= 1'b0;
            pend_rd <= 1'b0;
            count   <= '0;
            head    <= '0;
            tail    <= '0;
        end else begin
            pending <= fire;
            pend_rd <= fire & lsu.dtcm_cmd_read;
            if (pop) begin
                head <= wrap_inc(head);
            end
            if (push) begin
                tail <= wrap_inc(tail);
            end
            if (push && !pop) begin
                count <= count + 1'b1;
            end else if (pop && !push) begin
                count <= count - 1'b1;
            end
        end
    end

    // SRAM dout is only valid for one cycle, so it is captured here.
    always_ff @(posedge clk) begin
        if (push) begin
            rsp_buf[tail] <= rsp_cur;
        end
    end
endmodule

// File: tb/tb_dtcm_ctrl.sv
// Randomized bench for dtcm_ctrl against a queue-based response model.
// Includes a behavioural 1-cycle SRAM with byte write enables.
module tb_dtcm_ctrl;
    localparam int AW    = 16;
    localparam int DW    = 32;
    localparam int DEPTH = 2;
    localparam int WORDS = 16;

    logic            clk;
    logic            rst_n;
    logic            ram_cs;
    logic            ram_we;
    logic [AW-3:0]   ram_addr;
    logic [DW/8-1:0] ram_wem;
    logic [DW-1:0]   ram_din;
    logic [DW-1:0]   ram_dout;

    dtcm_if #(.AW(AW), .DW(DW)) lsu ();

    dtcm_ctrl #(.AW(AW), .DW(DW), .RSP_DEPTH(DEPTH)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .lsu      (lsu),
        .ram_cs   (ram_cs),
        .ram_we   (ram_we),
        .ram_addr (ram_addr),
        .ram_wem  (ram_wem),
        .ram_din  (ram_din),
        .ram_dout (ram_dout)
    );

    logic [DW-1:0] mem [WORDS];

    // dout is garbage except after a read, to expose late capture
    always @(posedge clk) begin
        if (ram_cs && ram_we) begin
            for (int b = 0; b < DW / 8; b++) begin
                if (ram_wem[b]) mem[ram_addr[3:0]][8*b +: 8] <= ram_din[8*b +: 8];
            end
        end
        if (ram_cs && !ram_we) ram_dout <= mem[ram_addr[3:0]];
        else ram_dout <= $urandom;
    end

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int checks = 0;
    int errors = 0;
    int fires  = 0;
    int pops   = 0;
    logic [DW-1:0] last_rsp;
    logic [DW-1:0] shadow [WORDS];
    logic [DW-1:0] exp_q [$];

    task automatic check(input string tag, input logic [DW-1:0] obs,
                         input logic [DW-1:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // One clock of the model: outstanding responses are the queue.
    task automatic step();
        logic exp_ready;
        logic fire;
        int   w;
        @(negedge clk);
        exp_ready = rst_n && (exp_q.size() < DEPTH);
        fire = lsu.dtcm_cmd_valid && exp_ready;
        check("cmd_ready", 32'(lsu.dtcm_cmd_ready), 32'(exp_ready));
        check("rsp_valid", 32'(lsu.dtcm_rsp_valid), 32'(exp_q.size() != 0));
        check("ram_cs", 32'(ram_cs), 32'(fire));
        check("ram_we", 32'(ram_we), 32'(fire && !lsu.dtcm_cmd_read));
        if (exp_q.size() != 0) begin
            check("rsp_rdata", lsu.dtcm_rsp_rdata, exp_q[0]);
            if (lsu.dtcm_rsp_ready) begin
                last_rsp = lsu.dtcm_rsp_rdata;
                pops++;
                void'(exp_q.pop_front());
            end
        end
        if (fire) begin
            fires++;
            w = int'(lsu.dtcm_cmd_addr[5:2]);
            if (lsu.dtcm_cmd_read) begin
                exp_q.push_back(shadow[w]);
            end else begin
                for (int b = 0; b < DW / 8; b++) begin
                    if (lsu.dtcm_cmd_wmask[b])
                        shadow[w][8*b +: 8] = lsu.dtcm_cmd_wdata[8*b +: 8];
                end
                exp_q.push_back('0);
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic cmd(input logic rd, input logic [AW-1:0] a,
                       input logic [DW-1:0] d, input logic [3:0] m);
        lsu.dtcm_cmd_valid = 1'b1;
        lsu.dtcm_cmd_read  = rd;
        lsu.dtcm_cmd_addr  = a;
        lsu.dtcm_cmd_wdata = d;
        lsu.dtcm_cmd_wmask = m;
    endtask

    task automatic idle(input int n);
        lsu.dtcm_cmd_valid = 1'b0;
        repeat (n) step();
    endtask

    initial begin
        rst_n = 1'b0;
        lsu.dtcm_cmd_valid = 1'b0;
        lsu.dtcm_cmd_read  = 1'b0;
        lsu.dtcm_cmd_addr  = '0;
        lsu.dtcm_cmd_wdata = '0;
        lsu.dtcm_cmd_wmask = '0;
        lsu.dtcm_rsp_ready = 1'b1;
        last_rsp = '0;
        lsu.dtcm_cmd_valid = 1'b1;
        repeat (2) step();
        rst_n = 1'b1;

        // preload the window back-to-back
        for (int i = 0; i < WORDS; i++) begin
            cmd(1'b0, AW'(i * 4), $urandom, 4'hF);
            step();
        end
        idle(2);

        // write then read
        cmd(1'b0, 16'h0010, 32'hDEADBEEF, 4'hF);
        step();
        idle(1);
        cmd(1'b1, 16'h0010, '0, 4'h0);
        step();
        idle(2);
        check("wr_rd_data", last_rsp, 32'hDEADBEEF);

        // byte mask
        cmd(1'b0, 16'h0020, 32'hFFFFFFFF, 4'hF);
        step();
        cmd(1'b0, 16'h0020, 32'h11223344, 4'h5);
        step();
        cmd(1'b1, 16'h0020, '0, 4'h0);
        step();
        idle(2);
        check("byte_mask", last_rsp, 32'hFF22FF44);

        // zero-mask write leaves memory untouched
        cmd(1'b0, 16'h0020, 32'h0BADF00D, 4'h0);
        step();
        cmd(1'b1, 16'h0020, '0, 4'h0);
        step();
        idle(2);
        check("zero_mask", last_rsp, 32'hFF22FF44);

        // back-to-back reads
        fires = 0;
        pops  = 0;
        for (int i = 0; i < 8; i++) begin
            cmd(1'b1, AW'(i * 4), '0, 4'h0);
            step();
        end
        check("b2b_fires", 32'(fires), 32'd8);
        idle(1);
        check("b2b_pops", 32'(pops), 32'd8);

        // back-pressure
        fires = 0;
        pops  = 0;
        lsu.dtcm_rsp_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            cmd(1'b1, AW'(4 + i * 4), '0, 4'h0);
            step();
        end
        check("bp_fires", 32'(fires), 32'd2);
        lsu.dtcm_rsp_ready = 1'b1;
        idle(3);
        check("bp_pops", 32'(pops), 32'd2);

        // alternate rsp_ready under continuous reads
        for (int i = 0; i < 40; i++) begin
            lsu.dtcm_rsp_ready = i[0];
            cmd(1'b1, AW'($urandom_range(0, 63)), '0, 4'h0);
            step();
        end
        lsu.dtcm_rsp_ready = 1'b1;
        idle(3);

        // random traffic
        for (int i = 0; i < 3000; i++) begin
            lsu.dtcm_rsp_ready = ($urandom_range(0, 3) != 0);
            cmd($urandom_range(0, 1) == 1, AW'($urandom_range(0, 63)),
                $urandom, 4'($urandom_range(0, 15)));
            lsu.dtcm_cmd_valid = ($urandom_range(0, 4) != 0);
            step();
        end
        lsu.dtcm_rsp_ready = 1'b1;
        idle(3);

        // reset with two responses buffered
        lsu.dtcm_rsp_ready = 1'b0;
        cmd(1'b1, 16'h0004, '0, 4'h0);
        step();
        step();
        idle(1);
        check("pre_rst_q", 32'(exp_q.size()), 32'd2);
        rst_n = 1'b0;
        #1;
        check("rst_rsp_valid", 32'(lsu.dtcm_rsp_valid), 32'd0);
        check("rst_cmd_ready", 32'(lsu.dtcm_cmd_ready), 32'd0);
        exp_q.delete();
        step();
        rst_n = 1'b1;
        lsu.dtcm_rsp_ready = 1'b1;
        idle(3);
        for (int i = 0; i < 200; i++) begin
            lsu.dtcm_rsp_ready = ($urandom_range(0, 1) == 1);
            cmd($urandom_range(0, 1) == 1, AW'($urandom_range(0, 63)),
                $urandom, 4'($urandom_range(0, 15)));
            step();
        end
        lsu.dtcm_rsp_ready = 1'b1;
        idle(3);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
